// File: rtl/quantize_stream_if.sv
// Stream bundle for quantize_stream: input beat handshake with its rounding mode,
// and the output beat handshake with per-lane saturation flags.
interface quantize_stream_if #(
    parameter int LANES = 4,
    parameter int IN_W  = 34,
    parameter int OUT_W = 16
);
    logic                   in_valid;
    logic                   in_ready;
    logic [LANES*IN_W-1:0]  in_data;
    logic [1:0]             round_mode;
    logic                   out_valid;
    logic                   out_ready;
    logic [LANES*OUT_W-1:0] out_data;
    logic [LANES-1:0]       out_sat;

    // Block side: consumes input beats, produces output beats.
    modport slave (
        input  in_valid, in_data, round_mode, out_ready,
        output in_ready, out_valid, out_data, out_sat
    );

    // Environment side: produces input beats, consumes output beats.
    modport master (
        output in_valid, in_data, round_mode, out_ready,
        input  in_ready, out_valid, out_data, out_sat
    );
endinterface

// File: rtl/quantize_stream.sv
// Multi-lane fixed-point requantizer: round in stage 1, shift and saturate in stage 2,
// with a saturating count of clipped lanes.
module quantize_stream #(
    parameter int IN_INT_W  = 18,
    parameter int IN_DEC_W  = 16,
    parameter int OUT_INT_W = 8,
    parameter int OUT_DEC_W = 8,
    parameter int LANES     = 4,
    parameter int SIGNED    = 1,
    parameter int CNT_W     = 16
) (
    input  logic                clk,
    input  logic                rst,
    quantize_stream_if.slave    bus,
    output logic [CNT_W-1:0]    sat_count,
    input  logic                clear_count
);
    localparam int IN_W  = IN_INT_W + IN_DEC_W;
    localparam int OUT_W = OUT_INT_W + OUT_DEC_W;
    localparam int D     = IN_DEC_W - OUT_DEC_W;
    localparam int SW    = IN_W + 1;   // rounded sum, one guard bit so it cannot wrap
    localparam int XW    = IN_W + 2;   // signed compare domain for both signednesses

    localparam logic [SW-1:0]        HALF  = SW'(1) << (D - 1);
    localparam logic signed [XW-1:0] ONE   = 1;
    localparam logic signed [XW-1:0] MAX_V = (SIGNED != 0) ? ((ONE <<< (OUT_W - 1)) - ONE)
                                                           : ((ONE <<< OUT_W) - ONE);
    localparam logic signed [XW-1:0] MIN_V = (SIGNED != 0) ? -(ONE <<< (OUT_W - 1)) : '0;

    if (D < 1 || IN_INT_W < OUT_INT_W) begin : g_bad_params
        $error("quantize_stream: need IN_DEC_W > OUT_DEC_W and IN_INT_W >= OUT_INT_W");
    end

    logic                   s1_valid;
    logic                   s2_valid;
    logic                   adv1;
    logic                   adv2;
    logic [SW-1:0]          sum_d  [LANES];
    logic [SW-1:0]          s1_sum [LANES];
    logic [LANES*OUT_W-1:0] q_pack;
    logic [LANES-1:0]       sat_d;
    logic [LANES*OUT_W-1:0] out_data_q;
    logic [LANES-1:0]       out_sat_q;

    assign adv2         = ~s2_valid | bus.out_ready;
    assign adv1         = ~s1_valid | adv2;
    assign bus.in_ready = adv1;
    assign bus.out_valid = s2_valid;
    assign bus.out_data  = out_data_q;
    assign bus.out_sat   = out_sat_q;

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        logic [IN_W-1:0]        x;
        logic [SW-1:0]          ext;
        logic [SW-1:0]          inc;
        logic signed [XW-1:0]   xv;
        logic signed [XW-1:0]   sh;
        logic [OUT_W-1:0]       q_l;
        logic                   sat_l;

        assign x   = bus.in_data[g*IN_W +: IN_W];
        assign ext = (SIGNED != 0) ? {x[IN_W-1], x} : {1'b0, x};

        // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and no latch is inferred.
        always_comb begin
            inc = '0;
            case (bus.round_mode)
                2'd1:    inc = HALF;
                2'd2:    inc = HALF - SW'(1) + SW'(x[D]);   // ties go to the even kept LSB
                default: inc = '0;
            endcase
        end

        assign sum_d[g] = ext + inc;

        // Widen once more so an unsigned sum using its guard bit stays non-negative here.
        assign xv = (SIGNED != 0) ? {s1_sum[g][SW-1], s1_sum[g]} : {1'b0, s1_sum[g]};
        assign sh = xv >>> D;

        always_comb begin
            q_l   = sh[OUT_W-1:0];
            sat_l = 1'b0;
            if (sh > MAX_V) begin
                q_l   = MAX_V[OUT_W-1:0];
                sat_l = 1'b1;
            end else if (sh < MIN_V) begin
                q_l   = MIN_V[OUT_W-1:0];
                sat_l = 1'b1;
            end
        end

        assign q_pack[g*OUT_W +: OUT_W] = q_l;
        assign sat_d[g]                 = sat_l;
    end

    // NOTE: sequential state is written with non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid   <= 1'b0;
            s2_valid   <= 1'b0;
            out_data_q <= '0;
            out_sat_q  <= '0;
        end else begin
            if (adv1) s1_valid <= bus.in_valid;
            if (adv2) begin
                s2_valid <= s1_valid;
                if (s1_valid) begin
                    out_data_q <= q_pack;
                    out_sat_q  <= sat_d;
                end
            end
        end
    end

    // NOTE: the stage-1 sum registers carry no reset; s1_valid qualifies them, so stale contents are never observed.
    always_ff @(posedge clk) begin
        if (adv1 && bus.in_valid) s1_sum <= sum_d;
    end

    logic [CNT_W:0] cnt_sum;
    assign cnt_sum = {1'b0, sat_count} + (CNT_W + 1)'($countones(out_sat_q));

    always_ff @(posedge clk) begin
        if (rst || clear_count) begin
            sat_count <= '0;
        end else if (s2_valid && bus.out_ready) begin
            sat_count <= cnt_sum[CNT_W] ? '1 : cnt_sum[CNT_W-1:0];
        end
    end
endmodule

// File: tb/tb_quantize_stream.sv
// Self-checking bench for quantize_stream: arithmetic reference model plus scoreboard,
// driven by directed rounding, saturation, backpressure, streaming and reset vectors.
module tb_quantize_stream;
    localparam int LANES = 4;
    localparam int IN_W  = 34;
    localparam int OUT_W = 16;
    localparam int D     = 8;
    localparam int CNT_W = 16;
    localparam longint SCALE = 256;   // 2^D

    typedef struct {
        logic [LANES*OUT_W-1:0] data;
        logic [LANES-1:0]       sat;
    } beat_t;

    typedef struct {
        longint     v;
        int         mode;
        logic [15:0] exp;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic clear_count = 1'b0;
    logic [CNT_W-1:0] sat_count;

    quantize_stream_if #(.LANES(LANES), .IN_W(IN_W), .OUT_W(OUT_W)) ifc ();

    quantize_stream dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (ifc),
        .sat_count  (sat_count),
        .clear_count(clear_count)
    );

    always #5 clk = ~clk;

    int compared = 0;
    int mismatched = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Round v / 2^D by the requested mode with plain integer arithmetic, then clip to 16-bit signed.
    function automatic logic [OUT_W:0] model_lane(input longint v, input int mode);
        longint q, r;
        q = v / SCALE;
        r = v - q * SCALE;
        if (r < 0) begin
            q = q - 1;
            r = r + SCALE;
        end
        if (mode == 1 && r >= SCALE / 2) q = q + 1;
        else if (mode == 2 && (r > SCALE / 2 || (r == SCALE / 2 && (q % 2) != 0))) q = q + 1;
        if (q > 32767)  return {1'b1, 16'h7FFF};
        if (q < -32768) return {1'b1, 16'h8000};
        return {1'b0, q[15:0]};
    endfunction

    function automatic beat_t model_beat(input logic [LANES*IN_W-1:0] d, input logic [1:0] mode);
        beat_t b;
        logic [OUT_W:0] r;
        for (int i = 0; i < LANES; i++) begin
            r = model_lane(longint'($signed(d[i*IN_W +: IN_W])), int'(mode));
            b.data[i*OUT_W +: OUT_W] = r[OUT_W-1:0];
            b.sat[i] = r[OUT_W];
        end
        return b;
    endfunction

    function automatic logic [LANES*IN_W-1:0] pack(input longint l0, input longint l1,
                                                    input longint l2, input longint l3);
        logic [LANES*IN_W-1:0] d;
        d[0*IN_W +: IN_W] = l0[IN_W-1:0];
        d[1*IN_W +: IN_W] = l1[IN_W-1:0];
        d[2*IN_W +: IN_W] = l2[IN_W-1:0];
        d[3*IN_W +: IN_W] = l3[IN_W-1:0];
        return d;
    endfunction

    // Scoreboard and continuous checks, sampled on the falling edge.
    beat_t                  sb [$];
    beat_t                  exp_b;
    int                     cnt_m = 0;
    int                     n_out = 0;
    logic                   prev_hold = 1'b0;
    logic [LANES*OUT_W-1:0] prev_data;
    logic [LANES*OUT_W-1:0] last_data = '0;
    logic [LANES-1:0]       last_sat = '0;

    always @(negedge clk) begin
        if (rst) begin
            sb.delete();
            cnt_m = 0;
            prev_hold = 1'b0;
        end else begin
            check("sat_count_track", sat_count, cnt_m);
            if (prev_hold) begin
                check("hold_valid", ifc.out_valid, 1'b1);
                check("hold_data", ifc.out_data, prev_data);
            end
            if (ifc.out_valid && ifc.out_ready) begin
                n_out++;
                if (sb.size() == 0) begin
                    check("spurious_beat", 64'(n_out), 64'(0));
                end else begin
                    exp_b = sb.pop_front();
                    check("beat_data", ifc.out_data, exp_b.data);
                    check("beat_sat", ifc.out_sat, exp_b.sat);
                    last_data = ifc.out_data;
                    last_sat  = ifc.out_sat;
                    if (!clear_count)
                        cnt_m = (cnt_m + $countones(exp_b.sat) > 65535) ? 65535
                              : cnt_m + $countones(exp_b.sat);
                end
            end
            if (clear_count) cnt_m = 0;
            if (ifc.in_valid && ifc.in_ready) sb.push_back(model_beat(ifc.in_data, ifc.round_mode));
            prev_hold = ifc.out_valid && !ifc.out_ready;
            prev_data = ifc.out_data;
        end
    end

    // Present one beat (caller is just after a rising edge) and hold it until accepted.
    task automatic send(input logic [LANES*IN_W-1:0] d, input logic [1:0] mode);
        int n = 0;
        ifc.in_valid   = 1'b1;
        ifc.in_data    = d;
        ifc.round_mode = mode;
        @(negedge clk);
        while (!ifc.in_ready && n < 200) begin
            n++;
            @(negedge clk);
        end
        if (n >= 200) check("send_timeout", 64'(n), 64'(0));
        @(posedge clk);
        #1;
        ifc.in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int n = 0;
        @(posedge clk);
        #2;
        while ((sb.size() != 0 || ifc.out_valid) && n < 100) begin
            n++;
            @(posedge clk);
            #2;
        end
        if (n >= 100) check("drain_timeout", 64'(n), 64'(0));
    endtask

    vec_t vecs [10] = '{
        '{64'sh18080,  0, 16'h0180}, '{64'sh18080,  1, 16'h0181},
        '{64'sh18080,  2, 16'h0180}, '{64'sh18080,  3, 16'h0180},
        '{64'sh18180,  0, 16'h0181}, '{64'sh18180,  1, 16'h0182},
        '{64'sh18180,  2, 16'h0182}, '{-64'sh18080, 0, 16'hFE7F},
        '{-64'sh18080, 1, 16'hFE80}, '{-64'sh18080, 2, 16'hFE80}
    };

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, t, run, n_before;
        logic [LANES*IN_W-1:0] sat_beat;

        ifc.in_valid   = 1'b0;
        ifc.in_data    = '0;
        ifc.round_mode = 2'd0;
        ifc.out_ready  = 1'b1;

        // Pin the reference model to hand-computed values.
        check("model_tie_even", model_lane(64'sh18080, 2), {1'b0, 16'h0180});
        check("model_neg_floor", model_lane(-64'sh18080, 0), {1'b0, 16'hFE7F});
        check("model_sat_hi", model_lane(64'shC80000, 0), {1'b1, 16'h7FFF});
        check("model_sat_lo", model_lane(-64'shC80000, 1), {1'b1, 16'h8000});

        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_out_valid", ifc.out_valid, 1'b0);
        check("rst_out_data", ifc.out_data, 64'h0);
        check("rst_out_sat", ifc.out_sat, 4'h0);
        check("rst_sat_count", sat_count, 16'h0);
        check("rst_in_ready", ifc.in_ready, 1'b1);
        @(posedge clk);
        #1;

        // Rounding modes, positive and negative.
        foreach (vecs[i]) begin
            send(pack(vecs[i].v, 64'sh12345, -64'sh0FF80, 64'sh3FF), 2'(vecs[i].mode));
            wait_drain();
            check($sformatf("round_vec%0d", i), last_data[15:0], vecs[i].exp);
            check($sformatf("round_sat%0d", i), last_sat, 4'h0);
        end

        // Saturation on lanes 1 and 2, then clear in the accept cycle of the next beat.
        sat_beat = pack(0, 64'shC80000, -64'shC80000, 0);
        send(sat_beat, 2'd0);
        wait_drain();
        check("sat_flags", last_sat, 4'b0110);
        check("sat_lane1", last_data[31:16], 16'h7FFF);
        check("sat_lane2", last_data[47:32], 16'h8000);
        check("sat_count_2", sat_count, 16'd2);
        ifc.out_ready = 1'b0;
        send(sat_beat, 2'd0);
        n = 0;
        while (!ifc.out_valid && n < 20) begin
            n++;
            @(posedge clk);
            #2;
        end
        check("clear_wait", 64'(n < 20), 64'(1));
        ifc.out_ready = 1'b1;
        clear_count   = 1'b1;
        @(posedge clk);
        #1 clear_count = 1'b0;
        check("sat_count_cleared", sat_count, 16'd0);
        wait_drain();

        // Backpressure: A and B fill the pipe, C must wait.
        ifc.out_ready = 1'b0;
        n_before = n_out;
        send(pack(64'sh0500, 0, 0, 0), 2'd0);
        send(pack(64'sh0A00, 0, 0, 0), 2'd0);
        ifc.in_valid = 1'b1;
        ifc.in_data  = pack(64'sh0F00, 0, 0, 0);
        @(negedge clk);
        check("bp_in_ready_low", ifc.in_ready, 1'b0);
        check("bp_out_is_A", ifc.out_data[15:0], 16'h0005);
        repeat (3) @(negedge clk);
        @(posedge clk);
        #1 ifc.out_ready = 1'b1;
        @(negedge clk);
        check("bp_in_ready_high", ifc.in_ready, 1'b1);
        @(posedge clk);
        #1 ifc.in_valid = 1'b0;
        wait_drain();
        check("bp_beat_count", 64'(n_out - n_before), 64'(3));
        check("bp_last_is_C", last_data[15:0], 16'h000F);

        // Streaming: 16 back-to-back beats, latency 2, unbroken output burst.
        fork
            begin
                for (int i = 0; i < 16; i++)
                    send(pack(longint'(i) * 64'sh1111 + 64'sh80, -(longint'(i) * 64'sh777),
                              longint'(i) * 64'sh40, 64'sh2000), 2'(i % 3));
            end
            begin
                n = 0;
                @(negedge clk);
                while (!(ifc.in_valid && ifc.in_ready) && n < 50) begin
                    n++;
                    @(negedge clk);
                end
                t = 0;
                while (!ifc.out_valid && t < 50) begin
                    t++;
                    @(negedge clk);
                end
                check("stream_latency", 64'(t), 64'(2));
                run = 0;
                while (ifc.out_valid && run < 40) begin
                    run++;
                    @(negedge clk);
                end
                check("stream_burst", 64'(run), 64'(16));
            end
        join
        wait_drain();

        // Build sat_count to 5, then reset with two beats in flight.
        send(pack(64'shC80000, -64'shC80000, 64'shC80000, -64'shC80000), 2'd0);
        send(pack(64'shC80000, 0, 0, 0), 2'd1);
        wait_drain();
        check("sat_count_5", sat_count, 16'd5);
        ifc.out_ready = 1'b0;
        send(pack(64'sh0100, 0, 0, 0), 2'd0);
        send(pack(64'sh0200, 0, 0, 0), 2'd0);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("mid_rst_out_valid", ifc.out_valid, 1'b0);
        check("mid_rst_sat_count", sat_count, 16'd0);
        check("mid_rst_in_ready", ifc.in_ready, 1'b1);
        n_before = n_out;
        ifc.out_ready = 1'b1;
        repeat (10) @(negedge clk);
        check("mid_rst_no_stale", 64'(n_out - n_before), 64'(0));
        check("scoreboard_empty", 64'(sb.size()), 64'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/quantize_stream.md
Name: quantize_stream

Overview:
- Streaming, multi-lane fixed-point requantizer for the attention datapath.
- Converts LANES packed input words from IN_INT_W.IN_DEC_W format to OUT_INT_W.OUT_DEC_W format.
- Supports a selectable rounding mode, signed or unsigned arithmetic, and per-lane saturation.
- Uses a 2-stage pipeline with valid/ready handshakes on both sides and a saturation-event counter. It sits between accumulator outputs and the next matrix stage.

Parameters:
IN_INT_W, 18, input integer bits (sign bit included when SIGNED=1)
IN_DEC_W, 16, input fractional bits
OUT_INT_W, 8, output integer bits (sign bit included when SIGNED=1)
OUT_DEC_W, 8, output fractional bits
LANES, 4, number of independent lanes per beat
SIGNED, 1, 1 = two's complement, 0 = unsigned
CNT_W, 16, width of the saturation counter

Ports:
clk  in  1  clock, all logic on the rising edge
rst  in  1  synchronous, active-high reset
in_valid  in  1  input beat valid
in_ready  out  1  block can accept a beat
in_data  in  LANES*(IN_INT_W+IN_DEC_W)  packed lanes, lane 0 in the LSBs
round_mode  in  2  0 = truncate (floor), 1 = round-half-up, 2 = round-half-even, 3 = reserved (behaves as 0); sampled with the beat
out_valid  out  1  output beat valid
out_ready  in  1  downstream accepts the beat
out_data  out  LANES*(OUT_INT_W+OUT_DEC_W)  packed results, lane 0 in the LSBs
out_sat  out  LANES  per-lane saturation flag, aligned with out_data
sat_count  out  CNT_W  running total of saturated lanes
clear_count  in  1  synchronous clear of sat_count

Behaviour:
- Legal parameters: D = IN_DEC_W - OUT_DEC_W >= 1; IN_INT_W >= OUT_INT_W. Any other setting is a static elaboration error.
- Reset:
  - s1_valid = 0, s2_valid = 0, out_valid = 0.
  - out_data = 0, out_sat = 0, sat_count = 0.
  - in_ready = 1 in the first cycle after reset.
  - Reset mid-stream discards all in-flight beats.
- Handshake:
  - A transfer occurs when valid and ready are both high.
  - adv2 = ~s2_valid | out_ready.
  - adv1 = ~s1_valid | adv2.
  - in_ready = adv1, purely combinational from the registered state and out_ready.
  - Once raised, out_valid and out_data stay stable until accepted.
- Latency: 2 cycles from input handshake to out_valid when there is no backpressure. Throughput: 1 beat per cycle.
- Stage 1 (per lane), registered together with the beat's round_mode:
  - Sign-extend (SIGNED=1) or zero-extend the input by 1 bit.
  - Add the rounding increment:
    - truncate: add 0.
    - half-up: add 2^(D-1).
    - half-even: add 2^(D-1) − 1 + bit[D] (the kept LSB). This gives ties-to-even.
  - The sum is IN_W+1 bits wide and cannot wrap.
- Stage 2 (per lane):
  - Arithmetic right shift by D (logical when SIGNED=0).
  - Compare against the output range:
    - signed: [−2^(OUT_W−1), 2^(OUT_W−1)−1].
    - unsigned: [0, 2^OUT_W−1].
  - Above max → max. Below min → min. In either case out_sat[lane] = 1.
- Negative rounding: truncate rounds toward −∞; half-up rounds ties toward +∞.
- sat_count:
  - On each output handshake, add popcount(out_sat).
  - Saturates at all-ones and never wraps.
  - clear_count takes priority over an increment in the same cycle (result is 0).
  - rst takes priority over everything.
- round_mode is per-beat: changing it mid-stream affects only beats accepted after the change.
- Lanes are fully independent; a saturated lane does not affect its neighbours.

Test Plan:
- Rounding: default params, lane0 = 0x18080 (1.5 + 2^-9). round_mode = 0 → 0x0180; mode 1 → 0x0180 + 1 = 0x0181; mode 2 → 0x0180 (tie, even LSB kept). Lane0 = 0x18180: mode 0 → 0x0181; mode 1 → 0x0182; mode 2 → 0x0182.
- Negative, signed: lane0 = −0x18080 (34-bit two's complement, −384.5 LSB). Mode 0 → 0xFE7F; mode 1 → 0xFE80; mode 2 → 0xFE80; out_sat = 0.
- Saturation: lane1 = 200.0 (0xC80000) → 0x7FFF; lane2 = −200.0 → 0x8000; out_sat = 4'b0110; sat_count becomes 2. Next beat with the same data and clear_count = 1 in the accept cycle → sat_count = 0.
- Backpressure: out_ready held low, in_valid high with beats A, B, C. A and B are accepted; in_ready = 0 while C is presented. out_data holds A stable. Raise out_ready → outputs A, B, C in order, one per cycle, nothing lost or duplicated.
- Throughput and latency: stream 16 beats with out_ready = 1. First out_valid appears 2 cycles after the first accept, then out_valid stays high for 16 consecutive cycles.
- Reset mid-operation: assert rst with 2 beats in flight and sat_count = 5. Next cycle: out_valid = 0, sat_count = 0, in_ready = 1; no stale beat appears afterwards.
